// File: rtl/qrs_adapt_fsm.sv
// qrs_adapt_fsm: adaptive QRS detection controller.
// Learns an initial threshold from the abs-diff max stream, then tracks it per
// accepted R-peak. It reports RR intervals and a running RR mean, and blanks
// peak search for a refractory window after each peak.
// Optional feature: define QRS_SEARCHBACK_EN to enable missed-beat searchback.
// That feature lowers the threshold when no peak arrives within 1.5x the mean RR.
module qrs_adapt_fsm #(
  parameter int DATA_WIDTH      = 11,
  parameter int CTR_WIDTH       = 24,
  parameter int INIT_SAMPLES    = 1080,
  parameter int REFRACT_SAMPLES = 72,
  parameter int TH_INIT_SHIFT   = 1,
  parameter int ALPHA_SHIFT     = 5,
  parameter int RR_AVG_DEPTH    = 8,
  parameter int TH_MIN          = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CTR_WIDTH-1:0]  i_ctr,
  input  logic [DATA_WIDTH-1:0] i_abs_max,
  input  logic                  i_abs_valid,
  input  logic                  i_peak_found,
  output logic                  o_qrs_search_en,
  output logic [DATA_WIDTH-1:0] o_rr_period,
  output logic [DATA_WIDTH-1:0] o_rr_avg,
  output logic                  o_rr_valid,
  output logic [CTR_WIDTH-1:0]  o_r_peak_location,
  output logic [DATA_WIDTH-1:0] o_qrs_threshold,
  output logic                  o_th_initialised,
  output logic                  o_missed_beat,
  output logic                  o_alg_active
);

  localparam int AVG_SH = $clog2(RR_AVG_DEPTH);
  localparam int SUM_W  = DATA_WIDTH + AVG_SH;
  localparam logic [CTR_WIDTH-1:0]  INIT_C  = CTR_WIDTH'(INIT_SAMPLES);
  localparam logic [CTR_WIDTH-1:0]  REFR_C  = CTR_WIDTH'(REFRACT_SAMPLES);
  localparam logic [CTR_WIDTH-1:0]  DMAX_C  = CTR_WIDTH'((1 << DATA_WIDTH) - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEARN   = 3'd1,
    S_TH_INIT = 3'd2,
    S_RUN     = 3'd3,
    S_UPDATE  = 3'd4,
    S_REFRACT = 3'd5
  } state_e;

  state_e state_q, state_d;

  // learning
  logic [CTR_WIDTH-1:0]  t0_q, t0_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  // threshold
  logic [DATA_WIDTH-1:0] th_q, th_d;
  logic                  th_init_q, th_init_d;
  logic                  search_en_q, search_en_d;
  // peak being processed and last accepted peak
  logic [CTR_WIDTH-1:0]  pk_q, pk_d;
  logic [DATA_WIDTH-1:0] amp_q, amp_d;
  logic [CTR_WIDTH-1:0]  loc_q, loc_d;
  logic                  have_pk_q, have_pk_d;
  logic                  have_rr_q, have_rr_d;
  // RR history ring and its running sum
  logic [RR_AVG_DEPTH-1:0][DATA_WIDTH-1:0] ring_q, ring_d;
  logic [AVG_SH-1:0]     wptr_q, wptr_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DATA_WIDTH-1:0] rr_period_q, rr_period_d;
  logic [DATA_WIDTH-1:0] rr_avg_q, rr_avg_d;
  logic                  rr_valid_q, rr_valid_d;

  // elapsed-sample helpers; modulo subtraction makes counter wrap transparent
  logic [CTR_WIDTH-1:0]  el_t0, el_pk, rr_raw;
  logic [DATA_WIDTH-1:0] rr;
  logic [DATA_WIDTH:0]   th_upd;

  assign el_t0  = i_ctr - t0_q;
  assign el_pk  = i_ctr - pk_q;
  // RR is measured between latched peak timestamps, so the one-cycle
  // UPDATE delay never leaks into the interval.
  assign rr_raw = pk_q - loc_q;
  assign rr     = (rr_raw > DMAX_C) ? '1 : rr_raw[DATA_WIDTH-1:0];
  // IIR threshold tracking, one extra bit to catch overflow before saturation
  assign th_upd = (DATA_WIDTH+1)'(th_q) - (DATA_WIDTH+1)'(th_q >> ALPHA_SHIFT)
                + (DATA_WIDTH+1)'(amp_q >> (ALPHA_SHIFT + 1));

`ifdef QRS_SEARCHBACK_EN
  localparam logic [DATA_WIDTH-1:0] THMIN_C = DATA_WIDTH'(TH_MIN);
  logic [CTR_WIDTH-1:0]  ref_q, ref_d, el_ref;
  logic [DATA_WIDTH:0]   sb_lim;
  logic [DATA_WIDTH-1:0] th_half;
  logic                  missed_q, missed_d, sb_fire;

  assign el_ref  = i_ctr - ref_q;
  assign sb_lim  = (DATA_WIDTH+1)'(rr_avg_q) + (DATA_WIDTH+1)'(rr_avg_q >> 1);
  assign sb_fire = have_rr_q && (el_ref > CTR_WIDTH'(sb_lim));
  assign th_half = th_q >> 1;

  // searchback reference and missed-beat pulse registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ref_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      ref_q    <= ref_d;
      missed_q <= missed_d;
    end
  end

  assign o_missed_beat = missed_q;
`else
  assign o_missed_beat = 1'b0;
`endif

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_abs_valid) state_d = S_LEARN;
      S_LEARN:   if (el_t0 >= INIT_C) state_d = S_TH_INIT;
      S_TH_INIT: state_d = S_RUN;
      S_RUN:     if (i_peak_found) state_d = S_UPDATE;
      S_UPDATE:  state_d = S_REFRACT;
      S_REFRACT: if (el_pk >= REFR_C) state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  // datapath / output next values per state
  always_comb begin
    t0_d        = t0_q;
    max_d       = max_q;
    th_d        = th_q;
    th_init_d   = th_init_q;
    pk_d        = pk_q;
    amp_d       = amp_q;
    loc_d       = loc_q;
    have_pk_d   = have_pk_q;
    have_rr_d   = have_rr_q;
    ring_d      = ring_q;
    wptr_d      = wptr_q;
    sum_d       = sum_q;
    rr_period_d = rr_period_q;
    rr_avg_d    = rr_avg_q;
    rr_valid_d  = 1'b0;
    // search is enabled exactly while the FSM sits in RUN
    search_en_d = (state_d == S_RUN);
`ifdef QRS_SEARCHBACK_EN
    ref_d       = ref_q;
    missed_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_abs_valid) begin
          t0_d  = i_ctr;
          max_d = '0;
        end
      end
      S_LEARN: begin
        if (i_abs_valid && (i_abs_max > max_q)) max_d = i_abs_max;
      end
      S_TH_INIT: begin
        th_d      = max_q >> TH_INIT_SHIFT;
        th_init_d = 1'b1;
      end
      S_RUN: begin
        // a peak in the same cycle outranks searchback
        if (i_peak_found) begin
          pk_d  = i_ctr;
          amp_d = i_abs_max;
        end
`ifdef QRS_SEARCHBACK_EN
        else if (sb_fire) begin
          th_d     = (th_half < THMIN_C) ? THMIN_C : th_half;
          missed_d = 1'b1;
          ref_d    = i_ctr;
        end
`endif
      end
      S_UPDATE: begin
        th_d      = th_upd[DATA_WIDTH] ? '1 : th_upd[DATA_WIDTH-1:0];
        loc_d     = pk_q;
        have_pk_d = 1'b1;
`ifdef QRS_SEARCHBACK_EN
        ref_d     = pk_q;
`endif
        // the very first peak only seeds the RR reference
        if (have_pk_q) begin
          rr_period_d = rr;
          rr_valid_d  = 1'b1;
          have_rr_d   = 1'b1;
          if (!have_rr_q) begin
            // first interval primes the whole ring so the mean is valid at once
            for (int i = 0; i < RR_AVG_DEPTH; i++) ring_d[i] = rr;
            sum_d  = SUM_W'(rr) << AVG_SH;
            wptr_d = '0;
          end else begin
            ring_d[wptr_q] = rr;
            wptr_d = wptr_q + AVG_SH'(1);
            sum_d  = sum_q + SUM_W'(rr) - SUM_W'(ring_q[wptr_q]);
          end
          rr_avg_d = DATA_WIDTH'(sum_d >> AVG_SH);
        end
      end
      default: ;
    endcase
  end

  // datapath registers, all cleared by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      t0_q        <= '0;
      max_q       <= '0;
      th_q        <= '0;
      th_init_q   <= 1'b0;
      search_en_q <= 1'b0;
      pk_q        <= '0;
      amp_q       <= '0;
      loc_q       <= '0;
      have_pk_q   <= 1'b0;
      have_rr_q   <= 1'b0;
      ring_q      <= '0;
      wptr_q      <= '0;
      sum_q       <= '0;
      rr_period_q <= '0;
      rr_avg_q    <= '0;
      rr_valid_q  <= 1'b0;
    end else begin
      t0_q        <= t0_d;
      max_q       <= max_d;
      th_q        <= th_d;
      th_init_q   <= th_init_d;
      search_en_q <= search_en_d;
      pk_q        <= pk_d;
      amp_q       <= amp_d;
      loc_q       <= loc_d;
      have_pk_q   <= have_pk_d;
      have_rr_q   <= have_rr_d;
      ring_q      <= ring_d;
      wptr_q      <= wptr_d;
      sum_q       <= sum_d;
      rr_period_q <= rr_period_d;
      rr_avg_q    <= rr_avg_d;
      rr_valid_q  <= rr_valid_d;
    end
  end

  assign o_qrs_search_en   = search_en_q;
  assign o_rr_period       = rr_period_q;
  assign o_rr_avg          = rr_avg_q;
  assign o_rr_valid        = rr_valid_q;
  assign o_r_peak_location = loc_q;
  assign o_qrs_threshold   = th_q;
  assign o_th_initialised  = th_init_q;
  assign o_alg_active      = (state_q != S_IDLE);

endmodule
